// File: rtl/uart_program_loader_if.sv
// uart_program_loader_if: byte stream in from the UART receiver, instruction-memory write port and CPU control out.
interface uart_program_loader_if #(parameter int ADDR_WIDTH = 10);
  logic [7:0] input_byte;
  logic byte_valid;
  logic mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic cpu_hold;
  logic load_done;
  logic load_error;
  modport master (
    output input_byte, byte_valid,
    input mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error
  );
  modport slave (
    input input_byte, byte_valid,
    output mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error
  );
endinterface

// File: rtl/uart_program_loader.sv
// uart_program_loader: parses sync/length/words/XOR-checksum frames into instruction-memory writes.
module uart_program_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT_CLKS = 1000000,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input logic clk,
  input logic rst_n,
  uart_program_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CHECK, ERROR} state_t;
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_WIDTH);
  state_t state_q, state_d;
  logic vld_q;
  logic we_q, we_d, hold_q, hold_d, done_q, done_d, err_q, err_d;
  logic [15:0] count_q, count_d, count_in;
  logic [16:0] word_q, word_d;
  logic [1:0] byte_q, byte_d;
  logic [23:0] sr_q, sr_d;
  logic [7:0] ck_q, ck_d;
  logic [31:0] tmo_q, tmo_d, wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic acc, active;
  always_comb begin
    acc = bus.byte_valid && !vld_q;
    active = state_q inside {LEN0, LEN1, DATA, CHECK};
    count_in = {bus.input_byte, count_q[7:0]};
    state_d = state_q;
    count_d = count_q;
    word_d = word_q;
    byte_d = byte_q;
    sr_d = sr_q;
    ck_d = ck_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    hold_d = hold_q;
    err_d = err_q;
    we_d = 1'b0;
    done_d = 1'b0;
    tmo_d = (active && !acc) ? tmo_q + 32'd1 : 32'd0;
    case (state_q)
      IDLE: if (acc && bus.input_byte == SYNC_BYTE) begin
        err_d = 1'b0;
        hold_d = 1'b1;
        ck_d = 8'd0;
        word_d = 17'd0;
        byte_d = 2'd0;
        state_d = LEN0;
      end
      LEN0: if (acc) begin
        count_d = {count_q[15:8], bus.input_byte};
        ck_d = ck_q ^ bus.input_byte;
        state_d = LEN1;
      end
      LEN1: if (acc) begin
        count_d = count_in;
        ck_d = ck_q ^ bus.input_byte;
        state_d = ({1'b0, count_in} > MAX_WORDS) ? ERROR : (count_in == 16'd0) ? CHECK : DATA;
      end
      DATA: if (acc) begin
        ck_d = ck_q ^ bus.input_byte;
        sr_d = {bus.input_byte, sr_q[23:8]};
        byte_d = byte_q + 2'd1;
        if (byte_q == 2'd3) begin
          we_d = 1'b1;
          addr_d = word_q[ADDR_WIDTH-1:0];
          wdata_d = {bus.input_byte, sr_q};
          word_d = word_q + 17'd1;
          state_d = (word_q + 17'd1 == {1'b0, count_q}) ? CHECK : DATA;
        end
      end
      CHECK: if (acc) begin
        done_d = bus.input_byte == ck_q;
        hold_d = bus.input_byte != ck_q;
        state_d = (bus.input_byte == ck_q) ? IDLE : ERROR;
      end
      ERROR: begin
        err_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (active && !acc && tmo_d == 32'(TIMEOUT_CLKS)) state_d = ERROR;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vld_q <= 1'b0;
      count_q <= '0;
      word_q <= '0;
      byte_q <= '0;
      sr_q <= '0;
      ck_q <= '0;
      tmo_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      hold_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q <= bus.byte_valid;
      count_q <= count_d;
      word_q <= word_d;
      byte_q <= byte_d;
      sr_q <= sr_d;
      ck_q <= ck_d;
      tmo_q <= tmo_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      we_q <= we_d;
      hold_q <= hold_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign bus.mem_we = we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_hold = hold_q;
  assign bus.load_done = done_q;
  assign bus.load_error = err_q;
endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader: table vectors, timing sequences and random frames checked against a frame-level model.
module tb_uart_program_loader;
  localparam int AW = 4;
  localparam int TMO = 1000;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  uart_program_loader_if #(.ADDR_WIDTH(AW)) bus();
  uart_program_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CLKS(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct packed {logic [AW-1:0] a; logic [31:0] d;} wr_t;
  typedef struct {logic [95:0] b; int n; int nwr; int done; logic err; logic hold; logic [31:0] w0; logic [31:0] w1;} vec_t;
  wr_t got_q[$], exp_q[$];
  int done_cnt = 0, checks = 0, errors = 0;
  logic exp_err, exp_hold;
  int exp_done;
  always @(negedge clk) if (rst_n) begin
    if (bus.mem_we) got_q.push_back(wr_t'({bus.mem_addr, bus.mem_wdata}));
    if (bus.load_done) done_cnt++;
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic accept_byte(input logic [7:0] b);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    @(negedge clk);
    bus.input_byte = b;
    bus.byte_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] s[$], input int hi_max);
    foreach (s[i]) begin
      accept_byte(s[i]);
      repeat ($urandom_range(0, hi_max - 1)) @(posedge clk);
    end
  endtask
  task automatic clear();
    got_q.delete();
    done_cnt = 0;
  endtask
  // Frame-level reference: walks the byte list frame by frame, never cycle by cycle.
  task automatic model(input logic [7:0] s[$], inout logic err, inout logic hold, output int done);
    int i, cnt;
    logic [7:0] ck;
    exp_q.delete();
    done = 0;
    i = 0;
    while (i < s.size()) begin
      if (s[i] != 8'hA5) begin
        i++;
        continue;
      end
      err = 1'b0;
      hold = 1'b1;
      cnt = {s[i+2], s[i+1]};
      ck = s[i+1] ^ s[i+2];
      i += 3;
      if (cnt > 2 ** AW) begin
        err = 1'b1;
        continue;
      end
      for (int w = 0; w < cnt; w++) begin
        exp_q.push_back(wr_t'({AW'(w), s[i+3], s[i+2], s[i+1], s[i]}));
        ck ^= s[i] ^ s[i+1] ^ s[i+2] ^ s[i+3];
        i += 4;
      end
      if (s[i] == ck) begin
        done++;
        hold = 1'b0;
      end else err = 1'b1;
      i++;
    end
  endtask
  task automatic compare(input string tag, input int edone, input logic eerr, input logic ehold);
    chk({tag, " write count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk({tag, " write"}, 64'(got_q[i]), 64'(exp_q[i]));
    chk({tag, " load_done pulses"}, 64'(done_cnt), 64'(edone));
    chk({tag, " load_error"}, 64'(bus.load_error), 64'(eerr));
    chk({tag, " cpu_hold"}, 64'(bus.cpu_hold), 64'(ehold));
  endtask
  task automatic chk_outputs_zero(input string tag);
    chk({tag, " mem_we"}, 64'(bus.mem_we), 64'd0);
    chk({tag, " mem_addr"}, 64'(bus.mem_addr), 64'd0);
    chk({tag, " mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    chk({tag, " cpu_hold"}, 64'(bus.cpu_hold), 64'd0);
    chk({tag, " load_done"}, 64'(bus.load_done), 64'd0);
    chk({tag, " load_error"}, 64'(bus.load_error), 64'd0);
  endtask
  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t v[5];
    logic [7:0] b;
    logic [7:0] good[$];
    logic [7:0] s[$];
    int len;
    logic [7:0] ck;
    good = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
    v[0] = '{96'hA502_0013_0000_0093_0010_0092, 12, 2, 1, 1'b0, 1'b0, 32'h0000_0013, 32'h0010_0093};
    v[1] = '{96'hA502_0013_0000_0093_0010_0093, 12, 2, 0, 1'b1, 1'b1, 32'h0000_0013, 32'h0010_0093};
    v[2] = '{96'hA502_0013_0000_0093_0010_0092, 12, 2, 1, 1'b0, 1'b0, 32'h0000_0013, 32'h0010_0093};
    v[3] = '{96'h3FFF00A5000000_0000000000, 7, 0, 1, 1'b0, 1'b0, 32'h0, 32'h0};
    v[4] = '{96'hA51100_000000000000000000, 3, 0, 0, 1'b1, 1'b1, 32'h0, 32'h0};
    bus.input_byte = 8'h00;
    bus.byte_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      clear();
      exp_q.delete();
      if (v[k].nwr > 0) exp_q.push_back(wr_t'({AW'(0), v[k].w0}));
      if (v[k].nwr > 1) exp_q.push_back(wr_t'({AW'(1), v[k].w1}));
      for (int j = 0; j < v[k].n; j++) begin
        b = v[k].b[95-8*j -: 8];
        accept_byte(b);
      end
      idle(6);
      compare($sformatf("vec%0d", k), v[k].done, v[k].err, v[k].hold);
    end
    clear();
    accept_byte(8'hA5);
    chk("sync clears load_error", 64'(bus.load_error), 64'd0);
    accept_byte(8'h01);
    accept_byte(8'h00);
    accept_byte(8'h11);
    accept_byte(8'h22);
    accept_byte(8'h33);
    chk("no write before 4th byte", 64'(bus.mem_we), 64'd0);
    accept_byte(8'h44);
    chk("mem_we after 4th byte", 64'(bus.mem_we), 64'd1);
    chk("mem_addr after 4th byte", 64'(bus.mem_addr), 64'd0);
    chk("mem_wdata after 4th byte", 64'(bus.mem_wdata), 64'h4433_2211);
    @(posedge clk);
    #1;
    chk("mem_we one cycle only", 64'(bus.mem_we), 64'd0);
    chk("mem_wdata held", 64'(bus.mem_wdata), 64'h4433_2211);
    accept_byte(8'h45);
    chk("one-word frame load_done", 64'(bus.load_done), 64'd1);
    clear();
    accept_byte(8'h3F);
    accept_byte(8'hFF);
    accept_byte(8'h00);
    chk("non-sync bytes ignored", 64'(bus.cpu_hold), 64'd0);
    accept_byte(8'hA5);
    chk("cpu_hold after sync", 64'(bus.cpu_hold), 64'd1);
    accept_byte(8'h00);
    accept_byte(8'h00);
    accept_byte(8'h00);
    chk("zero-length load_done", 64'(bus.load_done), 64'd1);
    chk("zero-length cpu_hold released", 64'(bus.cpu_hold), 64'd0);
    @(posedge clk);
    #1;
    chk("load_done one cycle only", 64'(bus.load_done), 64'd0);
    chk("zero-length no writes", 64'(got_q.size()), 64'd0);
    accept_byte(8'hA5);
    accept_byte(8'h00);
    accept_byte(8'h00);
    accept_byte(8'h01);
    chk("bad checksum load_error N+1", 64'(bus.load_error), 64'd0);
    @(posedge clk);
    #1;
    chk("bad checksum load_error N+2", 64'(bus.load_error), 64'd1);
    chk("bad checksum cpu_hold kept", 64'(bus.cpu_hold), 64'd1);
    accept_byte(8'hA5);
    accept_byte(8'h02);
    repeat (TMO) @(posedge clk);
    #1;
    chk("timeout load_error T+1", 64'(bus.load_error), 64'd0);
    @(posedge clk);
    #1;
    chk("timeout load_error T+2", 64'(bus.load_error), 64'd1);
    idle(2);
    clear();
    exp_err = 1'b1;
    exp_hold = 1'b1;
    send(good, 1);
    idle(6);
    model(good, exp_err, exp_hold, exp_done);
    compare("after timeout", exp_done, exp_err, exp_hold);
    clear();
    accept_byte(8'hA5);
    repeat (9) @(posedge clk);
    send(good[1:$], 1);
    idle(6);
    model(good, exp_err, exp_hold, exp_done);
    compare("long byte_valid", exp_done, exp_err, exp_hold);
    for (int j = 0; j < 8; j++) accept_byte(good[j]);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("async reset");
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear();
    exp_err = 1'b0;
    exp_hold = 1'b0;
    send(good, 1);
    idle(6);
    model(good, exp_err, exp_hold, exp_done);
    compare("after reset", exp_done, exp_err, exp_hold);
    for (int it = 0; it < 25; it++) begin
      s.delete();
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        s.push_back(b == 8'hA5 ? 8'h5A : b);
      end
      len = (it == 0) ? 16 : ($urandom_range(0, 7) == 0) ? $urandom_range(17, 700) : $urandom_range(0, 16);
      s.push_back(8'hA5);
      s.push_back(len[7:0]);
      s.push_back(len[15:8]);
      if (len <= 16) begin
        ck = len[7:0] ^ len[15:8];
        for (int j = 0; j < 4 * len; j++) begin
          b = 8'($urandom);
          s.push_back(b);
          ck ^= b;
        end
        if ($urandom_range(0, 4) == 0) ck ^= 8'(1 << $urandom_range(0, 7));
        s.push_back(ck);
      end
      clear();
      send(s, 3);
      idle(6);
      model(s, exp_err, exp_hold, exp_done);
      compare($sformatf("random%0d", it), exp_done, exp_err, exp_hold);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_program_loader.md
# uart_program_loader

Downstream consumer of the UART receiver (`uart_interface`) in the RISC-V FPGA system. Parses a framed byte stream into a program image: sync byte, 16-bit word count, little-endian 32-bit words, XOR checksum. Writes each assembled word into instruction memory and holds the CPU in reset while a load is in progress. Reports success with a one-cycle done pulse; reports bad checksum, oversize image or inter-byte timeout with a sticky error flag.

## Interface

- `ADDR_WIDTH`, default 10: instruction-memory word-address width; maximum image is 2^ADDR_WIDTH words.
- `TIMEOUT_CLKS`, default 1000000: idle clocks allowed between accepted bytes inside a frame (10 ms at 100 MHz).
- `SYNC_BYTE`, default 8'hA5: frame start marker.

- `clk`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `input_byte`  in  8  byte from the UART receiver (`output_byte`); stable while `byte_valid` is high.
- `byte_valid`  in  1  receiver `byte_received`; level of any length ≥1 cycle.
- `mem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `mem_addr`  out  ADDR_WIDTH  word address of the write.
- `mem_wdata`  out  32  word to write.
- `cpu_hold`  out  1  holds the CPU in reset while high.
- `load_done`  out  1  one-cycle pulse on a successful load.
- `load_error`  out  1  sticky error flag.

## Operation

- Byte acceptance: a byte is accepted at the clock edge where `byte_valid`=1 and the registered previous `byte_valid`=0 (rising-edge detect). Each receiver pulse therefore yields exactly one byte.
- FSM states:
  - IDLE:
    - An accepted byte equal to SYNC_BYTE clears `load_error`, sets `cpu_hold`, clears the XOR accumulator and word index, then → LEN0.
    - Any other byte is ignored.
  - LEN0: captures count[7:0], XORs it into the checksum, → LEN1.
  - LEN1: captures count[15:8] and XORs it in.
    - count > 2^ADDR_WIDTH → ERROR.
    - count = 0 → CHECK.
    - Otherwise → DATA.
  - DATA:
    - Each byte is XORed into the checksum and loaded LSB-first into the word shift register; `byte_idx` runs 0..3.
    - On `byte_idx`=3 the word is issued as a write at address `word_idx`, then `word_idx` increments and `byte_idx` returns to 0.
    - When `word_idx` reaches count → CHECK.
  - CHECK: the accepted byte is compared with the accumulator.
    - Equal → pulse `load_done`, clear `cpu_hold`, → IDLE.
    - Unequal → ERROR.
  - ERROR (transient, one cycle): sets `load_error`, → IDLE. `cpu_hold` stays 1 until a later frame succeeds.
- Checksum covers the length bytes and data bytes only. The sync byte and the checksum byte are excluded.
- Timeout: in LEN0, LEN1, DATA and CHECK, a counter increments every cycle and is cleared on each accepted byte. Reaching TIMEOUT_CLKS → ERROR. The counter is held at 0 in IDLE.
- SYNC_BYTE received mid-frame is treated as data, not as a restart.
- Reset, asynchronous and at any time:
  - State → IDLE.
  - All counters, the accumulator and the shift register → 0.
  - Outputs: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=0, `load_done`=0, `load_error`=0.
  - A partially written image is left in memory as-is.

## Timing

- All outputs are registered.
- The 4th byte of a word is accepted at edge N. `mem_we`=1 with valid `mem_addr`/`mem_wdata` during cycle N+1 only. `mem_addr`/`mem_wdata` hold their value until the next write.
- The sync byte is accepted at edge N. `cpu_hold` is 1 from cycle N+1.
- The checksum byte is accepted at edge N:
  - Match: `load_done`=1 for cycle N+1 only, and `cpu_hold`=0 from cycle N+1.
  - Mismatch: `load_error`=1 from cycle N+2 (one cycle spent in ERROR).
- Timeout: counter reaches TIMEOUT_CLKS at edge T → ERROR. `load_error`=1 from cycle T+2.
- A `byte_valid` held high for many cycles counts as one byte. A new byte requires `byte_valid` to return to 0 for ≥1 cycle.
- Minimum byte spacing supported: 2 cycles. This far exceeds UART rate (868 clocks/bit).

## Test plan

- Bench uses `TIMEOUT_CLKS`=1000 to keep timeout tests short.
- Stream A5 02 00 13 00 00 00 93 00 10 00 92:
  - writes (addr 0, 0x00000013) then (addr 1, 0x00100093), each `mem_we` exactly 1 cycle;
  - `load_done` pulses once; `cpu_hold` 1→0; `load_error`=0.
- Same stream with checksum 93:
  - both writes occur; no `load_done`; `load_error`=1; `cpu_hold` remains 1.
  - Then resend the good stream → `load_error` clears on A5, `load_done` pulses, `cpu_hold`=0.
- Stream 3F FF 00 A5 00 00 00:
  - first three bytes ignored (`cpu_hold` stays 0);
  - zero-length frame → no `mem_we`, `load_done` pulse.
- Stream A5 02, then 1000+ idle cycles → `load_error`=1, FSM in IDLE; a following A5 byte restarts a frame.
- Length check with `ADDR_WIDTH`=4:
  - count 17 (A5 11 00) → `load_error` without any writes;
  - count 16 is accepted.
- Reset and `byte_valid` edge cases:
  - Assert `rst_n`=0 after the 5th data byte of a 2-word frame → all outputs 0 immediately. After release, a full good frame loads correctly from address 0.
  - `byte_valid` held high for 10 cycles counts as a single byte.
